// File: rtl/mem_access_unit.sv
// Memory stage: executes EX/MEM loads/stores over a req/ack bus, presents the writeback triple to MEM/WB.
// Latency: non-memory ops pass through combinationally; bus ops take >= 3 cycles (IDLE, REQ..., DONE).
// Backpressure: stallreq_o holds the pipeline from acceptance until DONE; bus wait bounded by TIMEOUT_CYCLES.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stallreq_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

    // Counter is wide enough to hold TIMEOUT_CYCLES-1; it saturates when the timeout is disabled.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    wd_q;
    logic [7:0]    aluop_q;
    logic [1:0]    off_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          is_mem;
    logic          is_store;
    logic          misaligned;
    logic [3:0]    sel_c;
    logic [31:0]   wdata_c;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_data;

    // Decode the incoming op: access size, direction, alignment, byte lanes and replicated store data.
    always_comb begin
        is_mem     = 1'b1;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel_c      = 4'b0000;
        wdata_c    = 32'h0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                is_store = (aluop_i == EXE_SB_OP);
                sel_c    = 4'b1000 >> mem_addr_i[1:0];
                wdata_c  = {4{reg2_i[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                is_store   = (aluop_i == EXE_SH_OP);
                misaligned = mem_addr_i[0];
                sel_c      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_c    = {2{reg2_i[15:0]}};
            end
            EXE_LW_OP, EXE_SW_OP: begin
                is_store   = (aluop_i == EXE_SW_OP);
                misaligned = (mem_addr_i[1:0] != 2'b00);
                sel_c      = 4'b1111;
                wdata_c    = reg2_i;
            end
            default: is_mem = 1'b0;
        endcase
    end

    // Extract and extend the loaded byte/halfword from the captured big-endian bus word.
    always_comb begin
        load_data = 32'h0;
        case (off_q)
            2'd0:    load_byte = rdata_q[31:24];
            2'd1:    load_byte = rdata_q[23:16];
            2'd2:    load_byte = rdata_q[15:8];
            default: load_byte = rdata_q[7:0];
        endcase
        load_half = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (aluop_q)
            EXE_LB_OP:  load_data = {{24{load_byte[7]}}, load_byte};
            EXE_LBU_OP: load_data = {24'h0, load_byte};
            EXE_LH_OP:  load_data = {{16{load_half[15]}}, load_half};
            EXE_LHU_OP: load_data = {16'h0, load_half};
            EXE_LW_OP:  load_data = rdata_q;
            default:    load_data = 32'h0;
        endcase
    end

    // Bus FSM: accept an aligned op in IDLE, hold the request until ack or timeout, retire in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wd_q        <= 5'd0;
            aluop_q     <= 8'd0;
            off_q       <= 2'd0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_sel_o   <= 4'b0000;
            bus_wdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    cnt   <= '0;
                    if (is_mem && !misaligned) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_o   <= sel_c;
                        bus_wdata_o <= wdata_c;
                        wd_q        <= wd_i;
                        aluop_q     <= aluop_i;
                        off_q       <= mem_addr_i[1:0];
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the timeout edge still completes the access normally.
                    if (bus_ack_i) begin
                        rdata_q   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
                        bus_req_o <= 1'b0;
                        err_q     <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall, writeback and status flags; all forced low while reset is asserted.
    always_comb begin
        stallreq_o = 1'b0;
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'h0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                REQ: stallreq_o = 1'b1;
                DONE: begin
                    if (err_q) begin
                        bus_err_o = 1'b1;
                    end else if (!bus_we_o) begin
                        wd_o    = wd_q;
                        wreg_o  = 1'b1;
                        wdata_o = load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
